ram_responder: RTL and testbench

//  RAM-side responder for the ram* arbitration interface. Accepts one word

---
 rtl/ram_responder.sv | 126 ++++++++++++
 tb/tb_ram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Word-wide RAM responder for the ram* arbitration interface: one read or
// write in flight, fixed BUSY latency, registered ramstate/ramload.
module ram_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } req_t;

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT == 0) ? 0 : LAT - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

  ramstate_t     state_q, state_d;
  req_t          req_q, req_d, req_c;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_q, load_d;
  logic          any_req_c, illegal_c, match_c, commit_c, take_new_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   mem_q [DEPTH];

  assign req_c     = {ramREN, ramWEN, ramaddr, ramstore};
  assign any_req_c = ramREN | ramWEN;
  assign illegal_c = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                     ({1'b0, ramaddr} >= ADDR_LIMIT);
  assign match_c   = (req_c == req_q);
  assign idx_c     = ramaddr[AW+1:2];

  // Next-state: BUSY counts down on a stable tuple; FREE/ACCESS/ERROR accept new requests.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    commit_c   = 1'b0;
    take_new_c = 1'b0;
    case (state_q)
      BUSY: begin
        if (!any_req_c) begin
          state_d = FREE;
        end else if (illegal_c) begin
          state_d = ERROR;
        end else if (!match_c) begin
          req_d = req_c;
          cnt_d = CNT_INIT;
        end else if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACCESS: begin
        commit_c   = req_q.wen & match_c;
        take_new_c = 1'b1;
      end
      default: take_new_c = 1'b1;
    endcase

    if (take_new_c) begin
      if (!any_req_c) begin
        state_d = FREE;
      end else if (illegal_c) begin
        state_d = ERROR;
      end else begin
        req_d   = req_c;
        cnt_d   = CNT_INIT;
        state_d = (LAT == 0) ? ACCESS : BUSY;
      end
    end

    // On entry to ACCESS the live tuple equals the latched one, so ramaddr indexes the read.
    if (state_d == ACCESS && ramREN) begin
      load_d = mem_q[idx_c];
    end else if (state_d == ERROR) begin
      load_d = ERR_WORD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      req_q   <= '0;
      cnt_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  // Storage survives reset; a write lands only at the edge closing a matched ACCESS.
  always_ff @(posedge CLK) begin
    if (!RST && commit_c) begin
      mem_q[req_q.addr[AW+1:2]] <= req_q.store;
    end
  end

  assign ramstate = state_q;
  assign ramload  = load_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (LAT 2, 0, 3) driven by directed
// steps and random traffic, checked against an associative-array memory model.
module tb_ram_responder;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;
  localparam logic [31:0] BAD     = 32'hBAD1BAD1;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        ren [3];
  logic        wen [3];
  logic [31:0] addr [3];
  logic [31:0] store [3];
  logic [31:0] ld [3];
  logic [1:0]  st [3];

  int tests = 0;
  int fails = 0;
  logic [31:0] mm [int];

  always #5 clk = ~clk;

  ram_responder #(.LAT(2), .DEPTH(1024)) u_lat2 (
    .CLK(clk), .RST(rst[0]), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramload(ld[0]), .ramstate(st[0]));
  ram_responder #(.LAT(0), .DEPTH(1024)) u_lat0 (
    .CLK(clk), .RST(rst[1]), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramload(ld[1]), .ramstate(st[1]));
  ram_responder #(.LAT(3), .DEPTH(1024)) u_lat3 (
    .CLK(clk), .RST(rst[2]), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]), .ramload(ld[2]), .ramstate(st[2]));

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  function automatic int key(int d, logic [31:0] a);
    return d * 4096 + int'(a[11:2]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, logic r, logic w, logic [31:0] a, logic [31:0] s);
    ren[d] = r; wen[d] = w; addr[d] = a; store[d] = s;
  endtask

  task automatic idle(int d);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Legal request held until one cycle past ACCESS, then released.
  task automatic txn(int d, logic w, logic [31:0] a, logic [31:0] s);
    int lat = lat_of(d);
    drive(d, !w, w, a, s);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("busy", 32'(st[d]), 32'(S_BUSY));
    end
    tick();
    chk("access", 32'(st[d]), 32'(S_ACCESS));
    if (!w && mm.exists(key(d, a))) chk("rdata", ld[d], mm[key(d, a)]);
    tick();
    chk("reissue", 32'(st[d]), (lat == 0) ? 32'(S_ACCESS) : 32'(S_BUSY));
    if (w) mm[key(d, a)] = s;
    idle(d);
    tick();
    chk("release", 32'(st[d]), 32'(S_FREE));
  endtask

  // Illegal request held two cycles, then released.
  task automatic err(int d, logic r, logic w, logic [31:0] a, logic [31:0] s);
    drive(d, r, w, a, s);
    tick();
    chk("err_state", 32'(st[d]), 32'(S_ERROR));
    chk("err_load", ld[d], BAD);
    tick();
    chk("err_held", 32'(st[d]), 32'(S_ERROR));
    idle(d);
    tick();
    chk("err_clear", 32'(st[d]), 32'(S_FREE));
  endtask

  initial begin
    int kind, idx;
    logic [31:0] v;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      idle(d);
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_state", 32'(st[d]), 32'(S_FREE));
      chk("rst_load", ld[d], 32'h0);
    end

    // LAT=2 write then read of 0x40
    txn(0, 1'b1, 32'h40, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h40, 32'h0);

    // LAT=0 back-to-back reads, one per cycle
    for (int i = 0; i < 3; i++) txn(1, 1'b1, 32'(4 * i), $urandom);
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_state", 32'(st[1]), 32'(S_ACCESS));
      chk("b2b_data", ld[1], mm[key(1, 32'(4 * i))]);
      if (i < 2) drive(1, 1'b1, 1'b0, 32'(4 * (i + 1)), 32'h0);
      else idle(1);
    end
    tick();
    chk("b2b_free", 32'(st[1]), 32'(S_FREE));

    // LAT=0 write held through ACCESS, then immediate read of the same word
    drive(1, 1'b0, 1'b1, 32'hC, 32'hC0FFEE11);
    tick();
    chk("wr_access", 32'(st[1]), 32'(S_ACCESS));
    tick();
    chk("wr_reissue", 32'(st[1]), 32'(S_ACCESS));
    mm[key(1, 32'hC)] = 32'hC0FFEE11;
    drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
    tick();
    chk("wtr_state", 32'(st[1]), 32'(S_ACCESS));
    chk("wtr_data", ld[1], 32'hC0FFEE11);
    idle(1);
    tick();
    chk("wtr_free", 32'(st[1]), 32'(S_FREE));

    // LAT=3 address change during BUSY restarts the count
    txn(2, 1'b1, 32'h10, 32'h44444444);
    txn(2, 1'b1, 32'h14, 32'h55555555);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    chk("rs_c1", 32'(st[2]), 32'(S_BUSY));
    tick();
    chk("rs_c2", 32'(st[2]), 32'(S_BUSY));
    drive(2, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("rs_busy", 32'(st[2]), 32'(S_BUSY));
    end
    tick();
    chk("rs_access", 32'(st[2]), 32'(S_ACCESS));
    chk("rs_data", ld[2], 32'h55555555);
    idle(2);
    tick();
    chk("rs_free", 32'(st[2]), 32'(S_FREE));

    // Illegal requests leave storage untouched (0x1000 aliases word 0)
    txn(0, 1'b1, 32'h0, 32'h0BADF00D);
    err(0, 1'b1, 1'b1, 32'h0, 32'h11111111);
    err(0, 1'b0, 1'b1, 32'h2, 32'h22222222);
    err(0, 1'b0, 1'b1, 32'h1000, 32'h33333333);
    txn(0, 1'b0, 32'h0, 32'h0);

    // Reset during BUSY drops the write
    txn(0, 1'b1, 32'h80, 32'hA5A5A5A5);
    drive(0, 1'b0, 1'b1, 32'h80, 32'h12345678);
    tick();
    chk("rb_busy", 32'(st[0]), 32'(S_BUSY));
    rst[0] = 1'b1;
    tick();
    chk("rb_state", 32'(st[0]), 32'(S_FREE));
    chk("rb_load", ld[0], 32'h0);
    rst[0] = 1'b0;
    idle(0);
    tick();
    chk("rb_free", 32'(st[0]), 32'(S_FREE));
    txn(0, 1'b0, 32'h80, 32'h0);

    // ramstore changed during ACCESS: no commit, restart, new data lands
    txn(0, 1'b1, 32'h8, 32'h77777777);
    drive(0, 1'b0, 1'b1, 32'h8, 32'h88888888);
    tick();
    tick();
    tick();
    chk("sc_access1", 32'(st[0]), 32'(S_ACCESS));
    drive(0, 1'b0, 1'b1, 32'h8, 32'h99999999);
    tick();
    chk("sc_restart", 32'(st[0]), 32'(S_BUSY));
    tick();
    chk("sc_busy", 32'(st[0]), 32'(S_BUSY));
    tick();
    chk("sc_access2", 32'(st[0]), 32'(S_ACCESS));
    tick();
    chk("sc_reissue", 32'(st[0]), 32'(S_BUSY));
    mm[key(0, 32'h8)] = 32'h99999999;
    idle(0);
    tick();
    chk("sc_free", 32'(st[0]), 32'(S_FREE));
    txn(0, 1'b0, 32'h8, 32'h0);

    // Random traffic on LAT=2 over a small working set
    for (int i = 0; i < 16; i++) txn(0, 1'b1, 32'(4 * i), $urandom);
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 15);
      v    = $urandom;
      if (kind == 0) begin
        txn(0, 1'b1, 32'(4 * idx), v);
      end else if (kind == 1) begin
        txn(0, 1'b0, 32'(4 * idx), v);
      end else begin
        case ($urandom_range(0, 2))
          0: err(0, 1'b1, 1'b1, 32'(4 * idx), v);
          1: err(0, 1'(v[0]), 1'(~v[0]), 32'(4 * idx + $urandom_range(1, 3)), v);
          default: err(0, 1'(v[0]), 1'(~v[0]), 32'h1000 + 32'(4 * idx), v);
        endcase
      end
    end
    for (int i = 0; i < 16; i++) txn(0, 1'b0, 32'(4 * i), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
